exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
Multi-cycle control sequencer for the 8-bit, 9-bit-instruction datapath. It steps each instruction through fetch, decode, execute, optional data-memory access and writeback. It generates one-cycle enables for the instruction register, PC and register file, and runs a request/ready handshake with data memory that includes a timeout. It sits between the decoded control signals and the PC, instruction register, register file and data memory, and reports halt, fault and retired-instruction count.

Parameters:
CNT_W, 16, width of retired-instruction counter
MEM_TIMEOUT, 8, max MEM-state cycles without MEM_READY before fault (legal range 1..255)

Ports:
CLK  in  1  clock, all state on rising edge
RESET  in  1  synchronous active-high reset
START  in  1  begin execution from PC 0; honoured only in IDLE or HALTED
HALT_DEC  in  1  decoded halt, from instruction register
MEM_READ  in  1  decoded load
MEM_WRITE  in  1  decoded store
REG_WRITE  in  1  decoded register write
BRANCH_TAKEN  in  1  branch decoded and ALU ZERO
MEM_READY  in  1  data memory completes the access this cycle
PC_INIT  out  1  load PC with 0
PC_EN  out  1  update PC this edge
PC_SEL_TARGET  out  1  PC source: 1 selects branch target, 0 selects PC+1
IR_LOAD  out  1  capture instruction ROM output
MEM_REQ  out  1  data-memory access request
MEM_WE  out  1  write qualifier, valid while MEM_REQ=1
RF_WE  out  1  register-file write enable
DONE  out  1  halted
ERROR  out  1  memory timeout fault
STATE  out  3  current state, debug
INST_COUNT  out  CNT_W  retired instructions, saturating

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALTED=6, FAULT=7.
- RESET: next edge → IDLE; INST_COUNT=0; wait counter=0. All outputs 0 while in IDLE without START.
- Outputs are decoded from the state register and are not registered. Decoded inputs must stay stable from DECODE through WB (they are sourced from the instruction register).
- IDLE:
  - START=1: PC_INIT=1 this cycle, INST_COUNT clears at the edge, next state FETCH.
  - Otherwise stay in IDLE.
- FETCH: IR_LOAD=1; next state DECODE.
- DECODE:
  - HALT_DEC=1: next state HALTED. No PC_EN, no count increment.
  - Otherwise next state EXEC.
- EXEC:
  - MEM_READ or MEM_WRITE set: next state MEM, wait counter cleared.
  - Otherwise next state WB.
- MEM:
  - MEM_REQ=1; MEM_WE=MEM_WRITE. If MEM_READ and MEM_WRITE are both 1, the write wins.
  - MEM_READY=1: next state WB. MEM_READY is honoured in the first MEM cycle, so the minimum MEM dwell is 1 cycle.
  - MEM_READY=0 and wait counter = MEM_TIMEOUT-1: next state FAULT.
  - Otherwise the wait counter increments.
  - Result: MEM_REQ is high at most MEM_TIMEOUT cycles.
- WB:
  - RF_WE=REG_WRITE; PC_EN=1; PC_SEL_TARGET=BRANCH_TAKEN.
  - INST_COUNT increments, holding at all-ones.
  - Next state FETCH.
- HALTED:
  - DONE=1 every cycle.
  - START=1: same as IDLE+START (PC_INIT, count clear, FETCH); DONE drops with the state change.
- FAULT: ERROR=1; all enables 0; only RESET exits.
- START outside IDLE/HALTED is ignored.
- RESET overrides every state, including mid-MEM; MEM_REQ deasserts the cycle after the reset edge.
- Latency for a non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB). A memory instruction takes 4 + MEM dwell cycles.
- Enables PC_EN, RF_WE and IR_LOAD are never high for more than one consecutive cycle.

Decomposition:
- Shared package seq_pkg:
  - state_t enum with the encodings above.
  - STATE_W=3.
  - Default MEM_TIMEOUT and CNT_W constants.
- One natural sub-module, mem_wait_timer: a clear/increment counter with an expired flag, parameterised by MEM_TIMEOUT, used only in MEM. Everything else stays in one FSM.

Test Plan:
- ALU instruction: RESET, START at cycle 0 (PC_INIT=1), REG_WRITE=1, no memory.
  - STATE sequence 1,2,3,5.
  - IR_LOAD at cycle 1; RF_WE=PC_EN=1 only at cycle 4.
  - INST_COUNT=1 after cycle 4, then FETCH again.
- Load with MEM_READ=1 and MEM_READY raised in the 3rd MEM cycle.
  - MEM_REQ=1 for exactly 3 cycles with MEM_WE=0.
  - WB follows with RF_WE=1; INST_COUNT increments.
- Store with MEM_WRITE=1, REG_WRITE=0, MEM_READY=1 immediately.
  - 1 MEM cycle with MEM_WE=1; RF_WE=0 in WB.
- Branch with BRANCH_TAKEN=1.
  - PC_SEL_TARGET=1 in the same cycle as PC_EN. With BRANCH_TAKEN=0, PC_SEL_TARGET=0.
- Halt with HALT_DEC=1.
  - DONE=1 from the cycle after DECODE; no PC_EN; INST_COUNT unchanged.
  - START then gives PC_INIT=1, FETCH and INST_COUNT=0.
- Timeout and reset, with MEM_TIMEOUT=4 and MEM_READY held 0:
  - MEM_REQ high 4 cycles, then FAULT with ERROR=1; START ignored.
  - RESET gives IDLE with all outputs 0.
  - Separately, RESET in the 2nd MEM cycle gives IDLE on the next edge.
  - With CNT_W=4, 20 instructions leave INST_COUNT=15.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and defaults for the multi-cycle execution sequencer.
// State encodings are visible on the STATE debug port, so they are fixed here.
package seq_pkg;

  localparam int unsigned STATE_W         = 3;
  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned MEM_TIMEOUT_DEF = 8;
  // Wait counter width covers the full legal MEM_TIMEOUT range (1..255).
  localparam int unsigned WAIT_W          = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALTED = 3'd6,
    ST_FAULT  = 3'd7
  } state_t;

  function automatic logic is_mem_access(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEM-state cycles spent waiting for MEM_READY; 'expired' is combinational from the count.
// No handshake of its own: the sequencer clears it on MEM entry and steps it on each unserved MEM cycle.
module mem_wait_timer
  import seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Current MEM cycle is the last one allowed without MEM_READY.
  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer; 4 cycles per instruction plus MEM dwell.
// Stalls in MEM until MEM_READY, faulting after MEM_TIMEOUT cycles; outputs decode from state.
module exec_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic               HALT_DEC,
  input  logic               MEM_READ,
  input  logic               MEM_WRITE,
  input  logic               REG_WRITE,
  input  logic               BRANCH_TAKEN,
  input  logic               MEM_READY,
  output logic               PC_INIT,
  output logic               PC_EN,
  output logic               PC_SEL_TARGET,
  output logic               IR_LOAD,
  output logic               MEM_REQ,
  output logic               MEM_WE,
  output logic               RF_WE,
  output logic               DONE,
  output logic               ERROR,
  output logic [STATE_W-1:0] STATE,
  output logic [CNT_W-1:0]   INST_COUNT
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] inst_count_q;
  logic [CNT_W-1:0] inst_count_d;
  logic             wait_clr;
  logic             wait_inc;
  logic             wait_expired;
  logic             start_ok;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk     (CLK),
    .rst     (RESET),
    .clr     (wait_clr),
    .inc     (wait_inc),
    .expired (wait_expired)
  );

  assign start_ok = START && ((state_q == ST_IDLE) || (state_q == ST_HALTED));

  always_comb begin
    state_d      = state_q;
    inst_count_d = inst_count_q;
    wait_clr     = 1'b0;
    wait_inc     = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (START) begin
          state_d      = ST_FETCH;
          inst_count_d = '0;
        end
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = HALT_DEC ? ST_HALTED : ST_EXEC;
      end
      ST_EXEC: begin
        if (is_mem_access(MEM_READ, MEM_WRITE)) begin
          state_d  = ST_MEM;
          wait_clr = 1'b1;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (MEM_READY) begin
          state_d = ST_WB;
        end else if (wait_expired) begin
          state_d = ST_FAULT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        if (inst_count_q != '1) begin
          inst_count_d = inst_count_q + 1'b1;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      inst_count_q <= '0;
    end else begin
      state_q      <= state_d;
      inst_count_q <= inst_count_d;
    end
  end

  // Enables are pure state decodes so each lasts exactly one cycle per instruction.
  always_comb begin
    PC_INIT       = start_ok;
    PC_EN         = 1'b0;
    PC_SEL_TARGET = 1'b0;
    IR_LOAD       = 1'b0;
    MEM_REQ       = 1'b0;
    MEM_WE        = 1'b0;
    RF_WE         = 1'b0;
    DONE          = 1'b0;
    ERROR         = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        IR_LOAD = 1'b1;
      end
      ST_MEM: begin
        MEM_REQ = 1'b1;
        MEM_WE  = MEM_WRITE;
      end
      ST_WB: begin
        PC_EN         = 1'b1;
        PC_SEL_TARGET = BRANCH_TAKEN;
        RF_WE         = REG_WRITE;
      end
      ST_HALTED: begin
        DONE = 1'b1;
      end
      ST_FAULT: begin
        ERROR = 1'b1;
      end
      default: begin
        PC_EN = 1'b0;
      end
    endcase
  end

  assign STATE      = state_q;
  assign INST_COUNT = inst_count_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed and randomized instruction stream checked cycle-by-cycle against an instruction-level model.
module tb_exec_sequencer;

  localparam int CNT_W   = 4;
  localparam int TMO     = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [8:0] PCI = 9'h100;
  localparam logic [8:0] PCE = 9'h080;
  localparam logic [8:0] SEL = 9'h040;
  localparam logic [8:0] IRL = 9'h020;
  localparam logic [8:0] REQ = 9'h010;
  localparam logic [8:0] WE  = 9'h008;
  localparam logic [8:0] RFW = 9'h004;
  localparam logic [8:0] DN  = 9'h002;
  localparam logic [8:0] ER  = 9'h001;
  localparam logic [8:0] NONE = 9'h000;

  typedef struct packed {
    logic [8:0]       f;
    logic [2:0]       st;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  logic             CLK = 1'b0;
  logic             RESET, START, HALT_DEC, MEM_READ, MEM_WRITE, REG_WRITE, BRANCH_TAKEN, MEM_READY;
  logic             PC_INIT, PC_EN, PC_SEL_TARGET, IR_LOAD, MEM_REQ, MEM_WE, RF_WE, DONE, ERROR;
  logic [2:0]       STATE;
  logic [CNT_W-1:0] INST_COUNT;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;

  exec_sequencer #(
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .START         (START),
    .HALT_DEC      (HALT_DEC),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .REG_WRITE     (REG_WRITE),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .MEM_READY     (MEM_READY),
    .PC_INIT       (PC_INIT),
    .PC_EN         (PC_EN),
    .PC_SEL_TARGET (PC_SEL_TARGET),
    .IR_LOAD       (IR_LOAD),
    .MEM_REQ       (MEM_REQ),
    .MEM_WE        (MEM_WE),
    .RF_WE         (RF_WE),
    .DONE          (DONE),
    .ERROR         (ERROR),
    .STATE         (STATE),
    .INST_COUNT    (INST_COUNT)
  );

  always #5 CLK = ~CLK;

  function automatic obs_t ex(input int st, input logic [8:0] f, input int c);
    obs_t o;
    o.f   = f;
    o.st  = st[2:0];
    o.cnt = c[CNT_W-1:0];
    return o;
  endfunction

  // Inputs for this cycle are already applied; sample mid-cycle, then advance.
  task automatic cyc(input string tag, input obs_t exp);
    obs_t got;
    @(negedge CLK);
    got = {PC_INIT, PC_EN, PC_SEL_TARGET, IR_LOAD, MEM_REQ, MEM_WE, RF_WE, DONE, ERROR, STATE, INST_COUNT};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input string tag, input int cur_st);
    START = 1'b1;
    cyc(tag, ex(cur_st, PCI | ((cur_st == 6) ? DN : NONE), model_cnt));
    START = 1'b0;
    model_cnt = 0;
  endtask

  // One instruction from FETCH; ready_at is the MEM cycle (1-based) carrying MEM_READY, 0 = never.
  task automatic run_instr(input string tag, input logic h, input logic rd, input logic wr,
                           input logic rw, input logic br, input int ready_at, output logic faulted);
    logic served;
    faulted = 1'b0;
    served  = 1'b0;
    HALT_DEC = h; MEM_READ = rd; MEM_WRITE = wr; REG_WRITE = rw; BRANCH_TAKEN = br; MEM_READY = 1'b0;
    cyc({tag, "_fetch"}, ex(1, IRL, model_cnt));
    cyc({tag, "_decode"}, ex(2, NONE, model_cnt));
    if (h) begin
      cyc({tag, "_halted"}, ex(6, DN, model_cnt));
      return;
    end
    cyc({tag, "_exec"}, ex(3, NONE, model_cnt));
    if (rd || wr) begin
      for (int k = 1; k <= TMO && !served; k++) begin
        MEM_READY = (k == ready_at);
        cyc({tag, "_mem"}, ex(4, REQ | (wr ? WE : NONE), model_cnt));
        served = (k == ready_at);
      end
      MEM_READY = 1'b0;
      if (!served) begin
        cyc({tag, "_fault"}, ex(7, ER, model_cnt));
        faulted = 1'b1;
        return;
      end
    end
    cyc({tag, "_wb"}, ex(5, PCE | (rw ? RFW : NONE) | (br ? SEL : NONE), model_cnt));
    model_cnt = (model_cnt >= CNT_MAX) ? CNT_MAX : model_cnt + 1;
  endtask

  initial begin
    logic flt;
    logic r_rd, r_wr, r_rw, r_br;
    RESET = 1'b1; START = 1'b0; HALT_DEC = 1'b0; MEM_READ = 1'b0; MEM_WRITE = 1'b0;
    REG_WRITE = 1'b0; BRANCH_TAKEN = 1'b0; MEM_READY = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    cyc("reset_idle", ex(0, NONE, 0));
    cyc("idle_hold", ex(0, NONE, 0));
    do_start("start_idle", 0);

    run_instr("alu",      1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, flt);
    run_instr("load",     1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3, flt);
    run_instr("store",    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, flt);
    run_instr("br_taken", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, flt);
    run_instr("br_not",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, flt);
    run_instr("rd_wr",    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2, flt);

    for (int i = 0; i < 14; i++) begin
      r_rd = 1'($urandom_range(0, 1));
      r_wr = 1'($urandom_range(0, 1));
      r_rw = 1'($urandom_range(0, 1));
      r_br = 1'($urandom_range(0, 1));
      run_instr("rand", 1'b0, r_rd, r_wr, r_rw, r_br, int'($urandom_range(1, TMO)), flt);
    end

    // Twenty retired instructions on a 4-bit counter must saturate at 15.
    run_instr("halt", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, flt);
    cyc("halted_hold", ex(6, DN, 15));
    do_start("start_halted", 6);
    run_instr("post_halt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, flt);

    run_instr("timeout", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, flt);
    START = 1'b1;
    cyc("fault_start_ignored", ex(7, ER, model_cnt));
    cyc("fault_start_ignored2", ex(7, ER, model_cnt));
    START = 1'b0;
    RESET = 1'b1;
    cyc("fault_reset_cycle", ex(7, ER, model_cnt));
    RESET = 1'b0;
    model_cnt = 0;
    cyc("fault_cleared", ex(0, NONE, 0));

    do_start("start_again", 0);
    HALT_DEC = 1'b0; MEM_READ = 1'b1; MEM_WRITE = 1'b0; REG_WRITE = 1'b1; BRANCH_TAKEN = 1'b0; MEM_READY = 1'b0;
    cyc("midmem_fetch", ex(1, IRL, 0));
    cyc("midmem_decode", ex(2, NONE, 0));
    cyc("midmem_exec", ex(3, NONE, 0));
    cyc("midmem_mem1", ex(4, REQ, 0));
    RESET = 1'b1;
    cyc("midmem_mem2", ex(4, REQ, 0));
    RESET = 1'b0;
    MEM_READ = 1'b0; REG_WRITE = 1'b0;
    cyc("midmem_idle", ex(0, NONE, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
